urate_mul_ctrl: RTL and testbench

//  Sequencer for one unary-rate multiplier lane. Accepts a sign-magnitude operand pair,

---
 rtl/urate_pkg.sv | 18 +
 rtl/urate_vdc_gen.sv | 52 +++++
 rtl/urate_mul_ctrl.sv | 107 ++++++++++
 tb/tb_urate_mul_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/urate_pkg.sv
// Shared types for the unary-rate multiplier sequencer: FSM state encoding,
// default operand width, stream length and counter/accumulator types.
package urate_pkg;

   localparam int URATE_WIDTH = 8;
   localparam int STREAM_LEN  = 2 ** (URATE_WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   typedef logic [URATE_WIDTH-2:0] cnt_t;
   typedef logic [URATE_WIDTH-1:0] acc_t;

endpackage

// File: rtl/urate_vdc_gen.sv
// Stream counter and van der Corput word source: bit-reversed count while issuing,
// plus a one-cycle delayed copy of issue/count that lines up with the lane's register.
module urate_vdc_gen
   import urate_pkg::*;
#(
   parameter int WIDTH = URATE_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic             issue_i,
   output logic [WIDTH-2:0] randw_o,
   output logic [WIDTH-2:0] cnt_d_o,
   output logic             issue_d_o,
   output logic             last_o
);

   logic [WIDTH-2:0] cnt_q;
   logic [WIDTH-2:0] cnt_d_q;
   logic             issue_d_q;
   logic [WIDTH-2:0] rev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         cnt_d_q   <= '0;
         issue_d_q <= 1'b0;
      end else begin
         if (start_i) begin
            cnt_q <= '0;
         end else if (issue_i) begin
            cnt_q <= cnt_q + {{(WIDTH-2){1'b0}}, 1'b1};
         end
         issue_d_q <= issue_i;
         cnt_d_q   <= cnt_q;
      end
   end

   always_comb begin
      rev = '0;
      for (int b = 0; b < WIDTH - 1; b++) begin
         rev[b] = cnt_q[WIDTH-2-b];
      end
   end

   // Word is forced to zero outside the stream so the lane sees a quiet input.
   assign randw_o   = issue_i ? rev : '0;
   assign last_o    = issue_i && (cnt_q == '1);
   assign cnt_d_o   = cnt_d_q;
   assign issue_d_o = issue_d_q;

endmodule

// File: rtl/urate_mul_ctrl.sv
// Sequencer for one unary-rate multiplier lane: accept, stream, drain, report.
// Optional URATE_MUL_CTRL_ZERO_SKIP_EN short-circuits zero-magnitude operands to DONE.
module urate_mul_ctrl
   import urate_pkg::*;
#(
   parameter int WIDTH = URATE_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_data_i,
   input  logic [WIDTH-1:0] i_data_w,
   output logic [WIDTH-2:0] o_data_w,
   output logic [WIDTH-2:0] o_randW,
   output logic             o_bit_i,
   input  logic             i_bit,
   output logic             o_res_valid,
   input  logic             i_res_ready,
   output logic             o_res_sign,
   output logic [WIDTH-1:0] o_res_mag,
   output logic             o_busy
);

   state_e           state_q;
   logic             sign_q;
   logic [WIDTH-2:0] mag_i_q;
   logic [WIDTH-2:0] mag_w_q;
   logic [WIDTH-1:0] acc_q;

   logic             accept;
   logic             issue;
   logic             issue_d;
   logic             last;
   logic [WIDTH-2:0] cnt_d;

   assign accept = (state_q == ST_IDLE) && i_valid;
   assign issue  = (state_q == ST_RUN);

   urate_vdc_gen #(.WIDTH(WIDTH)) u_vdc (
      .clk       (clk),
      .rst_n     (rst_n),
      .start_i   (accept),
      .issue_i   (issue),
      .randw_o   (o_randW),
      .cnt_d_o   (cnt_d),
      .issue_d_o (issue_d),
      .last_o    (last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         sign_q  <= 1'b0;
         mag_i_q <= '0;
         mag_w_q <= '0;
         acc_q   <= '0;
      end else begin
         // Accumulation follows the delayed issue flag, so it spills into DRAIN.
         if (issue_d) begin
            acc_q <= acc_q + {{(WIDTH-1){1'b0}}, i_bit};
         end
         case (state_q)
            ST_IDLE: begin
               if (i_valid) begin
                  mag_i_q <= i_data_i[WIDTH-2:0];
                  mag_w_q <= i_data_w[WIDTH-2:0];
                  sign_q  <= i_data_i[WIDTH-1] ^ i_data_w[WIDTH-1];
                  acc_q   <= '0;
                  state_q <= ST_RUN;
`ifdef URATE_MUL_CTRL_ZERO_SKIP_EN
                  if ((i_data_i[WIDTH-2:0] == '0) || (i_data_w[WIDTH-2:0] == '0)) begin
                     sign_q  <= 1'b0;
                     state_q <= ST_DONE;
                  end
`endif
               end
            end
            ST_RUN: begin
               if (last) begin
                  state_q <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               state_q <= ST_DONE;
            end
            ST_DONE: begin
               if (i_res_ready) begin
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_ready     = (state_q == ST_IDLE);
   assign o_busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign o_res_valid = (state_q == ST_DONE);
   assign o_res_sign  = sign_q;
   assign o_res_mag   = acc_q;
   assign o_data_w    = mag_w_q;
   assign o_bit_i     = issue_d && (cnt_d < mag_i_q);

endmodule

// File: tb/tb_urate_mul_ctrl.sv
// Bench for urate_mul_ctrl: directed and random operand pairs against a counting
// reference model, with a registered lane model closing the product-bit loop.
module tb_urate_mul_ctrl;
   import urate_pkg::*;

   localparam int W = 8;
   localparam int L = STREAM_LEN;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         i_valid = 1'b0;
   logic         o_ready;
   logic [W-1:0] i_data_i = '0;
   logic [W-1:0] i_data_w = '0;
   logic [W-2:0] o_data_w;
   logic [W-2:0] o_randW;
   logic         o_bit_i;
   logic         i_bit;
   logic         o_res_valid;
   logic         i_res_ready = 1'b0;
   logic         o_res_sign;
   logic [W-1:0] o_res_mag;
   logic         o_busy;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   urate_mul_ctrl #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_valid     (i_valid),
      .o_ready     (o_ready),
      .i_data_i    (i_data_i),
      .i_data_w    (i_data_w),
      .o_data_w    (o_data_w),
      .o_randW     (o_randW),
      .o_bit_i     (o_bit_i),
      .i_bit       (i_bit),
      .o_res_valid (o_res_valid),
      .i_res_ready (i_res_ready),
      .o_res_sign  (o_res_sign),
      .o_res_mag   (o_res_mag),
      .o_busy      (o_busy)
   );

   // Lane: registers the random word, compares against the weight magnitude.
   logic [W-2:0] lane_randw_q;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) lane_randw_q <= '0;
      else        lane_randw_q <= o_randW;
   end
   assign i_bit = o_bit_i & (lane_randw_q < o_data_w);

   function automatic int vdc(input int n);
      int r = 0;
      int v = n;
      repeat (W - 1) begin
         r = r * 2 + (v % 2);
         v = v / 2;
      end
      return r;
   endfunction

   function automatic int ref_mag(input int mi, input int mw);
      int c = 0;
      for (int s = 0; s < L; s++) begin
         if (s < mi && vdc(s) < mw) c++;
      end
      return c;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_op(input logic [W-1:0] di, input logic [W-1:0] dw,
                        input bit seq, input int hold);
      int k;
      int mi;
      int mw;
      int e_mag;
      int e_sign;
      int e_lat;
      k = 0;
      while (o_ready !== 1'b1 && k < 50) begin
         step();
         k++;
      end
      chk("ready_before_op", o_ready, 1);
      mi     = int'(di[W-2:0]);
      mw     = int'(dw[W-2:0]);
      e_mag  = ref_mag(mi, mw);
      e_sign = di[W-1] ^ dw[W-1];
      e_lat  = L + 2;
`ifdef URATE_MUL_CTRL_ZERO_SKIP_EN
      if (mi == 0 || mw == 0) begin
         e_sign = 0;
         e_lat  = 1;
      end
`endif
      i_data_i = di;
      i_data_w = dw;
      i_valid  = 1'b1;
      step();
      i_valid = 1'b0;
      k = 1;
      while (o_res_valid !== 1'b1 && k < 400) begin
         if (seq) begin
            chk("randw", o_randW, (k <= L) ? vdc(k - 1) : 0);
            chk("bit_i", o_bit_i, (k >= 2 && k <= L + 1 && (k - 2) < mi) ? 1 : 0);
            chk("busy", o_busy, 1);
            chk("ready_busy", o_ready, 0);
         end
         step();
         k++;
      end
      chk("latency", k, e_lat);
      chk("res_mag", o_res_mag, e_mag);
      chk("res_sign", o_res_sign, e_sign);
      chk("ready_done", o_ready, 0);
      for (int h = 0; h < hold; h++) begin
         i_valid  = 1'b1;
         i_data_i = W'($urandom);
         i_data_w = W'($urandom);
         step();
         chk("hold_valid", o_res_valid, 1);
         chk("hold_mag", o_res_mag, e_mag);
         chk("hold_sign", o_res_sign, e_sign);
         chk("hold_ready", o_ready, 0);
      end
      i_valid     = 1'b0;
      i_res_ready = 1'b1;
      step();
      i_res_ready = 1'b0;
      chk("release_valid", o_res_valid, 0);
      chk("release_ready", o_ready, 1);
      chk("release_busy", o_busy, 0);
   endtask

   initial begin
      // Power-on reset
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", o_ready, 1);
      chk("rst_valid", o_res_valid, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_randw", o_randW, 0);
      chk("rst_bit_i", o_bit_i, 0);
      chk("rst_mag", o_res_mag, 0);
      chk("rst_sign", o_res_sign, 0);
      chk("rst_data_w", o_data_w, 0);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // Directed operand pairs
      do_op(8'h40, 8'h40, 1'b1, 0);
      do_op(8'hFF, 8'h7F, 1'b1, 0);
      do_op(8'h00, 8'h55, 1'b1, 0);
      do_op(8'h95, 8'h00, 1'b0, 0);
      do_op(8'hC3, 8'h2A, 1'b0, 5);

      // Asynchronous reset in the middle of a stream
      i_data_i = 8'h40;
      i_data_w = 8'h40;
      i_valid  = 1'b1;
      step();
      i_valid = 1'b0;
      repeat (49) step();
      chk("mid_busy", o_busy, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_ready", o_ready, 1);
      chk("arst_busy", o_busy, 0);
      chk("arst_valid", o_res_valid, 0);
      chk("arst_randw", o_randW, 0);
      chk("arst_bit_i", o_bit_i, 0);
      chk("arst_mag", o_res_mag, 0);
      chk("arst_sign", o_res_sign, 0);
      chk("arst_data_w", o_data_w, 0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk("post_rst_ready", o_ready, 1);
      do_op(8'h40, 8'h40, 1'b0, 0);

      // Random operand pairs
      for (int r = 0; r < 8; r++) begin
         do_op(W'($urandom), W'($urandom), ($urandom_range(0, 1) == 1), $urandom_range(0, 3));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
